// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC requantisation stage.
//   - Default width constants (IW, OW, SH) for Q16.16 in, Q8.8 out
//   - OUT_MAX / OUT_MIN clamp values of the output format
//   - requant_beat_t: output-stage payload {data, last, sat}
//   - rnd_shift(): optional round-half-up followed by arithmetic right shift
// -----------------------------------------------------------------------------
package mac_pkg;

  localparam int INT_W_IN   = 16;
  localparam int FRAC_W_IN  = 16;
  localparam int INT_W_OUT  = 8;
  localparam int FRAC_W_OUT = 8;

  localparam int IW = INT_W_IN + FRAC_W_IN;
  localparam int OW = INT_W_OUT + FRAC_W_OUT;
  localparam int SH = FRAC_W_IN - FRAC_W_OUT;

  localparam logic signed [OW-1:0] OUT_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] OUT_MIN = {1'b1, {(OW-1){1'b0}}};

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
    logic          sat;
  } requant_beat_t;

  // Evaluated on a 64-bit sign-extended operand so the rounding bias can
  // never wrap; the caller truncates to IW+1 bits, which always holds the
  // shifted result.
  function automatic logic signed [63:0] rnd_shift(
    input logic signed [63:0] x,
    input int                 sh,
    input bit                 rnd
  );
    logic signed [63:0] bias;
    bias = '0;
    if (rnd && (sh > 0)) begin
      bias = 64'sd1 <<< (sh - 1);
    end
    return (x + bias) >>> sh;
  endfunction

endpackage

// File: rtl/mac_pipe_reg.sv
// -----------------------------------------------------------------------------
// mac_pipe_reg
// One valid/ready register slice with a W-bit payload. Loads whenever it is
// empty or its current content leaves this cycle, giving full throughput.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid/in_ready/in_data    upstream handshake and payload
//   out_valid/out_ready/out_data downstream handshake and payload
// -----------------------------------------------------------------------------
module mac_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  assign in_ready  = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (in_ready) begin
      valid_reg <= in_valid;
      if (in_valid) begin
        data_reg <= in_data;
      end
    end
  end

endmodule

// File: rtl/mac_requant.sv
// -----------------------------------------------------------------------------
// mac_requant
// Rounds and saturates a signed Q16.16 accumulator stream to signed Q8.8.
// Two register slices: stage 1 holds the rounded/shifted value, stage 2 holds
// the clamped output. Full throughput, lossless under backpressure.
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last   input stream
//   s_ovf_flg/s_udf_flg             MAC overflow/underflow flags per beat
//   m_valid/m_ready/m_data/m_last   output stream
//   m_sat                           beat was clamped
// Optional (macro REQUANT_STATS_EN):
//   stat_clr                        synchronous clear of both counters
//   sat_cnt, pkt_cnt                saturating counts of clamped beats and
//                                   of packets (last beats) delivered
// -----------------------------------------------------------------------------
module mac_requant
  import mac_pkg::*;
#(
  parameter int int_width_in   = 16,
  parameter int frac_width_in  = 16,
  parameter int int_width_out  = 8,
  parameter int frac_width_out = 8,
  parameter int round_en       = 1
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [int_width_in+frac_width_in-1:0] s_data,
  input  logic                                  s_last,
  input  logic                                  s_ovf_flg,
  input  logic                                  s_udf_flg,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [int_width_out+frac_width_out-1:0] m_data,
  output logic                                  m_last,
  output logic                                  m_sat
`ifdef REQUANT_STATS_EN
  ,
  input  logic                                  stat_clr,
  output logic [15:0]                           sat_cnt,
  output logic [15:0]                           pkt_cnt
`endif
);

  localparam int IW_L = int_width_in + frac_width_in;
  localparam int OW_L = int_width_out + frac_width_out;
  localparam int SH_L = frac_width_in - frac_width_out;
  localparam int R_W  = IW_L + 1;
  localparam int P1_W = R_W + 3;

  localparam logic signed [63:0] R_MAX = (64'sd1 <<< (OW_L - 1)) - 64'sd1;
  localparam logic signed [63:0] R_MIN = -(64'sd1 <<< (OW_L - 1));

  if (frac_width_out > frac_width_in) begin : g_bad_frac
    $error("frac_width_out must not exceed frac_width_in");
  end
  // The output payload struct is sized from the package output width.
  if (OW_L != OW) begin : g_bad_ow
    $error("output width must match mac_pkg::OW");
  end
  if (R_W > 64) begin : g_bad_iw
    $error("input width too large for the rounding arithmetic");
  end

  // Stage 1: round and shift on accept
  logic signed [R_W-1:0] r_in;
  logic [P1_W-1:0]       p1_in;
  logic [P1_W-1:0]       p1_out;
  logic                  v1;
  logic                  ready1;

  assign r_in  = R_W'(rnd_shift(64'($signed(s_data)), SH_L, round_en != 0));
  assign p1_in = {r_in, s_last, s_ovf_flg, s_udf_flg};

  mac_pipe_reg #(.W(P1_W)) u_stage1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (s_valid),
    .in_ready  (s_ready),
    .in_data   (p1_in),
    .out_valid (v1),
    .out_ready (ready1),
    .out_data  (p1_out)
  );

  // Stage 2: clamp to the output range; MAC flags override, ovf first
  logic signed [R_W-1:0] r1;
  logic                  last1;
  logic                  ovf1;
  logic                  udf1;
  logic signed [63:0]    r1_wide;
  requant_beat_t         beat2_in;
  requant_beat_t         beat2_out;

  assign {r1, last1, ovf1, udf1} = p1_out;
  assign r1_wide = 64'(r1);

  always_comb begin
    beat2_in.data = r1[OW_L-1:0];
    beat2_in.last = last1;
    beat2_in.sat  = 1'b0;
    if (ovf1) begin
      beat2_in.data = OUT_MAX;
      beat2_in.sat  = 1'b1;
    end else if (udf1) begin
      beat2_in.data = OUT_MIN;
      beat2_in.sat  = 1'b1;
    end else if (r1_wide > R_MAX) begin
      beat2_in.data = OUT_MAX;
      beat2_in.sat  = 1'b1;
    end else if (r1_wide < R_MIN) begin
      beat2_in.data = OUT_MIN;
      beat2_in.sat  = 1'b1;
    end
  end

  mac_pipe_reg #(.W($bits(requant_beat_t))) u_stage2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (v1),
    .in_ready  (ready1),
    .in_data   (beat2_in),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (beat2_out)
  );

  assign m_data = beat2_out.data;
  assign m_last = beat2_out.last;
  assign m_sat  = beat2_out.sat;

`ifdef REQUANT_STATS_EN
  logic        out_hs;
  logic [15:0] sat_cnt_reg;
  logic [15:0] pkt_cnt_reg;

  assign out_hs  = m_valid && m_ready;
  assign sat_cnt = sat_cnt_reg;
  assign pkt_cnt = pkt_cnt_reg;

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_cnt_reg <= '0;
      pkt_cnt_reg <= '0;
    end else if (stat_clr) begin
      sat_cnt_reg <= '0;
      pkt_cnt_reg <= '0;
    end else begin
      if (out_hs && m_sat && (sat_cnt_reg != 16'hFFFF)) begin
        sat_cnt_reg <= sat_cnt_reg + 16'd1;
      end
      if (out_hs && m_last && (pkt_cnt_reg != 16'hFFFF)) begin
        pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mac_requant.sv
// -----------------------------------------------------------------------------
// tb_mac_requant
// Directed bench for mac_requant: reset state, rounding, saturation, flags,
// backpressure, throughput, mid-stream reset and (with REQUANT_STATS_EN)
// the statistics counters.
// -----------------------------------------------------------------------------
module tb_mac_requant;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        s_ovf_flg;
  logic        s_udf_flg;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
  logic        m_sat;
`ifdef REQUANT_STATS_EN
  logic        stat_clr;
  logic [15:0] sat_cnt;
  logic [15:0] pkt_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mac_requant dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ovf_flg (s_ovf_flg),
    .s_udf_flg (s_udf_flg),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_sat     (m_sat)
`ifdef REQUANT_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .sat_cnt   (sat_cnt),
    .pkt_cnt   (pkt_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, then check: not visible one cycle after accept,
  // visible with expected {valid,last,sat,data} two cycles after accept.
  task automatic single(input string tag, input logic [31:0] d, input logic ovf,
                        input logic udf, input logic last,
                        input logic [15:0] ed, input logic es);
    s_valid = 1'b1; s_data = d; s_ovf_flg = ovf; s_udf_flg = udf; s_last = last;
    #1;
    chk({tag, ".s_ready"}, 64'(s_ready), 64'd1);
    tick();
    s_valid = 1'b0; s_ovf_flg = 1'b0; s_udf_flg = 1'b0; s_last = 1'b0;
    chk({tag, ".early"}, 64'(m_valid), 64'd0);
    tick();
    chk({tag, ".out"}, 64'({m_valid, m_last, m_sat, m_data}), 64'({1'b1, last, es, ed}));
    $display("beat %s in=0x%08h -> data=0x%04h sat=%0d", tag, d, m_data, m_sat);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    int got;
    logic acc;
    logic hs;

    reset_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    s_ovf_flg = 1'b0; s_udf_flg = 1'b0; m_ready = 1'b1;
`ifdef REQUANT_STATS_EN
    stat_clr = 1'b0;
`endif
    tick();
    tick();
    chk("reset.outs", 64'({m_valid, m_last, m_sat, m_data}), 64'd0);
`ifdef REQUANT_STATS_EN
    chk("reset.cnts", 64'({sat_cnt, pkt_cnt}), 64'd0);
`endif
    reset_n = 1'b1;
    tick();
    chk("reset.s_ready", 64'(s_ready), 64'd1);

    // Rounding
    single("rnd0", 32'h0001_8000, 1'b0, 1'b0, 1'b0, 16'h0180, 1'b0);
    single("rnd1", 32'h0000_0080, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0);
    single("rnd2", 32'hFFFF_FF80, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    single("rnd3", 32'hFFFF_FF7F, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);

    // Saturation and MAC flags
    single("sat_hi",  32'h0080_0000, 1'b0, 1'b0, 1'b0, 16'h7FFF, 1'b1);
    single("sat_lo",  32'hFF7F_0000, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b1);
    single("sat_edge",32'h007F_FF00, 1'b0, 1'b0, 1'b0, 16'h7FFF, 1'b0);
    single("flg_ovf", 32'h0000_0000, 1'b1, 1'b0, 1'b0, 16'h7FFF, 1'b1);
    single("flg_udf", 32'h0000_0000, 1'b0, 1'b1, 1'b0, 16'h8000, 1'b1);
    single("flg_both",32'h0000_0000, 1'b1, 1'b1, 1'b1, 16'h7FFF, 1'b1);

    // Backpressure: m_ready low in cycles 2..6
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      m_ready = !(c >= 2 && c <= 6);
      s_valid = (sent < 6);
      s_data  = 32'((sent + 1) << 16);
      s_last  = (sent == 5);
      #1;
      if (c == 2) chk("bp.s_ready_drop", 64'(s_ready), 64'd0);
      if (c == 7) chk("bp.s_ready_back", 64'(s_ready), 64'd1);
      if (m_valid) begin
        chk($sformatf("bp.out%0d", got), 64'({m_last, m_data}),
            64'({got == 5, 16'((got + 1) << 8)}));
      end
      acc = s_valid && s_ready;
      hs  = m_valid && m_ready;
      tick();
      if (acc) sent++;
      if (hs) begin
        $display("bp out%0d data=0x%04h", got, 16'((got + 1) << 8));
        got++;
      end
    end
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    chk("bp.sent", 64'(sent), 64'd6);
    chk("bp.got", 64'(got), 64'd6);
    chk("bp.drained", 64'(m_valid), 64'd0);

    // Throughput: 100 back-to-back beats, last on beat 100
    for (int c = 0; c < 103; c++) begin
      s_valid = (c < 100);
      s_data  = 32'((c + 1) << 16);
      s_last  = (c == 99);
      #1;
      if (c >= 2 && c < 102) begin
        chk($sformatf("tp.out%0d", c - 1), 64'({m_valid, m_last, m_data}),
            64'({1'b1, c == 101, 16'((c - 1) << 8)}));
      end
      if (c == 102) chk("tp.end", 64'(m_valid), 64'd0);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    $display("tp 100 beats streamed");

    // Reset with two beats in flight
    s_valid = 1'b1; s_data = 32'h0009_0000;
    tick();
    s_data = 32'h000A_0000;
    tick();
    s_valid = 1'b0;
    chk("rst.inflight", 64'(m_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rst.during", 64'({m_valid, m_data}), 64'd0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("rst.after0", 64'(m_valid), 64'd0);
    tick();
    chk("rst.after1", 64'(m_valid), 64'd0);
    single("rst.first", 32'h0007_0000, 1'b0, 1'b0, 1'b1, 16'h0700, 1'b0);

`ifdef REQUANT_STATS_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("st.cleared", 64'({sat_cnt, pkt_cnt}), 64'd0);
    // 3 packets of 4 beats, saturated beats at 0,3,5,8,10
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'b1;
      s_data  = (i == 0 || i == 3 || i == 5 || i == 8 || i == 10) ? 32'h0080_0000 : 32'h0001_0000;
      s_last  = (i % 4 == 3);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    repeat (4) tick();
    chk("st.pkt_cnt", 64'(pkt_cnt), 64'd3);
    chk("st.sat_cnt", 64'(sat_cnt), 64'd5);
    $display("stats pkt_cnt=%0d sat_cnt=%0d", pkt_cnt, sat_cnt);
    // Clear coincident with a saturated last beat handshake
    s_valid = 1'b1; s_data = 32'h0080_0000; s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    tick();
    chk("st.clr_beat", 64'({m_valid, m_last, m_sat}), 64'b111);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("st.clr_win", 64'({sat_cnt, pkt_cnt}), 64'd0);
    tick();
    chk("st.clr_hold", 64'({sat_cnt, pkt_cnt}), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
